// File: rtl/intersection_timer.sv
// rtl/intersection_timer.sv - sensor debouncer and restartable tick/timeout timer for a traffic light FSM
//
// Purpose:
//   Conditions the raw car sensor (2-flop synchronizer + debounce) and runs
//   the timing the light FSM needs: a prescaler producing a periodic tick,
//   an elapsed-tick counter with short/long timeout decodes, and a sticky
//   "car waiting" flag. The FSM pulses restart on every state change to
//   clear all timing.
//
// Ports:
//   clk      in   clock, all state changes on its rising edge
//   reset_n  in   asynchronous active-low reset
//   SN       in   raw asynchronous car sensor (1 = car present)
//   restart  in   single-cycle pulse from the light FSM; clears timing state
//   S        out  debounced sensor level
//   W        out  sticky car-waiting flag, set by S since the last restart
//   T        out  short timeout (SHORT_TICKS ticks) reached since last restart
//   L        out  long timeout (LONG_TICKS ticks) reached since last restart
//   tick     out  one-cycle pulse on every prescaler wrap

module intersection_timer #(
    parameter int DIV         = 50000000,
    parameter int SHORT_TICKS = 3,
    parameter int LONG_TICKS  = 10,
    parameter int DEB_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SN,
    input  logic restart,
    output logic S,
    output logic W,
    output logic T,
    output logic L,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = $clog2(LONG_TICKS + 1);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [EW-1:0] E_SHORT   = EW'(SHORT_TICKS);
    localparam logic [EW-1:0] E_LONG    = EW'(LONG_TICKS);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] deb_cnt_q;
    logic          s_q;
    logic          w_q;
    logic [PW-1:0] pre_q;
    logic [EW-1:0] elapsed_q;

    // ------------------------------------------------------------------
    // Synchronizer and debouncer (independent of restart)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= SN;
            sync2_q <= sync1_q;
        end
    end

    // The count tracks how many consecutive edges the synchronized level
    // has disagreed with S. The edge that would make it DEB_CYCLES is the
    // edge that accepts the new level, so the count never holds that value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_q <= '0;
            s_q       <= 1'b0;
        end else if (sync2_q == s_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
            s_q       <= sync2_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, elapsed-tick counter and sticky waiting flag
    // ------------------------------------------------------------------
    // restart masks tick so a coincident restart never advances elapsed.
    assign tick = (pre_q == PRE_LAST) && !restart;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else if (restart || (pre_q == PRE_LAST)) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Saturates at LONG_TICKS so L stays asserted however long we wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elapsed_q <= '0;
        end else if (restart) begin
            elapsed_q <= '0;
        end else if (tick && (elapsed_q < E_LONG)) begin
            elapsed_q <= elapsed_q + 1'b1;
        end
    end

    // restart wins over a simultaneous S so the flag only reflects cars
    // seen after the light changed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q <= 1'b0;
        end else if (restart) begin
            w_q <= 1'b0;
        end else if (s_q) begin
            w_q <= 1'b1;
        end
    end

    assign S = s_q;
    assign W = w_q;
    assign T = (elapsed_q >= E_SHORT);
    assign L = (elapsed_q >= E_LONG);

endmodule

// File: tb/tb_intersection_timer.sv
// tb/tb_intersection_timer.sv - self-checking bench for intersection_timer
module tb_intersection_timer;

    localparam int DIV   = 4;
    localparam int SHORT = 2;
    localparam int LONG  = 5;
    localparam int DEB   = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic SN      = 1'b0;
    logic restart = 1'b0;
    logic S, W, T, L, tick;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since the last restart/reset, the
    // sensor delay line, the recent synchronized values, S and W.
    int m_c;
    bit m_s, m_w, m_s1, m_s2;
    bit hist[$];

    intersection_timer #(
        .DIV        (DIV),
        .SHORT_TICKS(SHORT),
        .LONG_TICKS (LONG),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .SN     (SN),
        .restart(restart),
        .S      (S),
        .W      (W),
        .T      (T),
        .L      (L),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_elapsed();
        return (m_c / DIV > LONG) ? LONG : m_c / DIV;
    endfunction

    task automatic model_reset();
        m_c  = 0;
        m_s  = 0;
        m_w  = 0;
        m_s1 = 0;
        m_s2 = 0;
        hist.delete();
    endtask

    // S accepts a new level once the last DEB synchronized samples all
    // disagree with it.
    task automatic model_edge(input bit sn, input bit rs);
        bit s_pre;
        bit all_diff;
        s_pre = m_s;
        hist.push_back(m_s2);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_s) all_diff = 0;
            if (all_diff) m_s = !m_s;
        end
        m_w  = rs ? 1'b0 : (s_pre ? 1'b1 : m_w);
        m_c  = rs ? 0 : ((m_c < 10000) ? m_c + 1 : m_c);
        m_s2 = m_s1;
        m_s1 = sn;
    endtask

    task automatic compare();
        int e;
        e = exp_elapsed();
        check("S", S, m_s);
        check("W", W, m_w);
        check("T", T, (e >= SHORT));
        check("L", L, (e >= LONG));
        check("tick", tick, ((m_c % DIV) == DIV - 1) && !restart);
    endtask

    // Called just after a falling edge: drive, take one rising edge, check.
    task automatic cycle(input bit sn, input bit rs);
        SN      = sn;
        restart = rs;
        @(posedge clk);
        model_edge(sn, rs);
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset between edges; outputs must drop immediately.
    task automatic do_reset(input string tag);
        #1;
        reset_n = 1'b0;
        #1;
        check({tag, "_S"}, S, 0);
        check({tag, "_W"}, W, 0);
        check({tag, "_T"}, T, 0);
        check({tag, "_L"}, L, 0);
        check({tag, "_tick"}, tick, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        compare();
    endtask

    initial begin
        bit sn_r;
        model_reset();

        // Reset state
        #1;
        check("rst_S", S, 0);
        check("rst_W", W, 0);
        check("rst_T", T, 0);
        check("rst_L", L, 0);
        check("rst_tick", tick, 0);
        @(negedge clk);
        reset_n = 1'b1;
        compare();

        // Timeout: tick, T after 8 edges, L after 20, saturation to E100
        cycle(0, 1);
        repeat (100) cycle(0, 0);

        // Restart mid-count, then restart coincident with a tick cycle
        cycle(0, 1);
        repeat (9) cycle(0, 0);
        cycle(0, 1);
        repeat (25) cycle(0, 0);
        cycle(0, 1);
        repeat (3) cycle(0, 0);
        cycle(0, 1);
        repeat (10) cycle(0, 0);

        // Debounce: held level is accepted, 2-cycle pulse is rejected
        repeat (6) cycle(1, 0);
        repeat (8) cycle(0, 0);
        cycle(1, 1);
        cycle(1, 0);
        repeat (8) cycle(0, 0);

        // Sticky flag: W survives S falling; restart vs coincident S
        repeat (6) cycle(1, 0);
        repeat (6) cycle(0, 0);
        cycle(0, 1);
        repeat (5) cycle(1, 0);
        cycle(1, 1);
        cycle(1, 0);
        repeat (6) cycle(0, 0);

        // Randomized traffic with occasional restarts and resets
        sn_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) sn_r = !sn_r;
            if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
            else cycle(sn_r, ($urandom_range(0, 29) == 0));
        end

        // Reset mid-count with S, W, T and L all high
        cycle(1, 1);
        repeat (30) cycle(1, 0);
        check("pre_rst_L", L, 1);
        check("pre_rst_S", S, 1);
        do_reset("mid_rst");
        repeat (12) cycle(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_timer.md
INTERSECTION_TIMER -- requirements
Module: intersection_timer

Interface
REQ-001 The module SHALL have parameter DIV, default 50000000, meaning clock cycles per timer tick (DIV >= 2).
REQ-002 The module SHALL have parameter SHORT_TICKS, default 3, meaning ticks until short timeout T asserts (>= 1).
REQ-003 The module SHALL have parameter LONG_TICKS, default 10, meaning ticks until long timeout L asserts (> SHORT_TICKS).
REQ-004 The module SHALL have parameter DEB_CYCLES, default 1000, meaning consecutive stable cycles needed to accept a sensor change (>= 1).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port SN, input, 1 bit: raw, asynchronous car sensor (1 = car present).
REQ-008 The module SHALL have port restart, input, 1 bit: single-cycle pulse from the light FSM on every state change; restarts timing.
REQ-009 The module SHALL have port S, output, 1 bit: debounced sensor level.
REQ-010 The module SHALL have port W, output, 1 bit: sticky "car waiting" flag, set by S since the last restart.
REQ-011 The module SHALL have port T, output, 1 bit: short timeout reached since the last restart.
REQ-012 The module SHALL have port L, output, 1 bit: long timeout reached since the last restart.
REQ-013 The module SHALL have port tick, output, 1 bit: one-cycle pulse on every prescaler wrap.

Function
REQ-014 SN SHALL pass through a 2-flop synchronizer; sync output = SN delayed 2 edges.
REQ-015 Debounce: a counter SHALL count consecutive cycles with sync != S; reset to 0 whenever sync == S; when count reaches DEB_CYCLES, S <= sync and count <= 0 on that edge.
REQ-016 A glitch shorter than DEB_CYCLES cycles at the sync output SHALL leave S unchanged.
REQ-017 Prescaler: counter 0..DIV-1, +1 per cycle, wraps to 0; tick = 1 combinationally while count == DIV-1 and restart == 0.
REQ-018 Elapsed counter: width clog2(LONG_TICKS+1); +1 on each edge where tick = 1; saturates at LONG_TICKS (no wrap).
REQ-019 T SHALL be (elapsed >= SHORT_TICKS), decoded from the registered elapsed counter.
REQ-020 L SHALL be (elapsed >= LONG_TICKS), decoded from the registered elapsed counter.
REQ-021 On an edge with restart = 1, the prescaler SHALL become 0, elapsed SHALL become 0 and W SHALL become 0; restart overrides a coincident tick (no increment).
REQ-022 W SHALL become 1 on any edge with S = 1 and restart = 0; it holds until restart or reset. Restart takes priority when both apply in the same cycle.
REQ-023 restart held high for multiple cycles SHALL keep all timing state at 0; timing resumes from the edge after restart falls.
REQ-024 The debouncer and synchronizer SHALL be unaffected by restart.
REQ-025 Timing from a restart edge E0: tick during the cycle after edge E(k*DIV-1); elapsed = k after edge E(k*DIV); T rises after edge E(SHORT_TICKS*DIV); L rises after edge E(LONG_TICKS*DIV).

Reset
REQ-026 While reset_n = 0, all of the following SHALL be 0 immediately and asynchronously: synchronizer flops, debounce count, S, W, prescaler, elapsed, T, L and tick.
REQ-027 After reset_n rises, timing SHALL run as if a restart occurred on the last reset edge; no restart pulse is required.
REQ-028 Assertion of reset_n mid-count SHALL discard all progress; no partial state survives.

Verification (DIV=4, SHORT_TICKS=2, LONG_TICKS=5, DEB_CYCLES=3)
REQ-029 Reset check: assert reset_n=0 mid-count with T=L=1 -> S, W, T, L and tick read 0 at once, without waiting for a clock edge.
REQ-030 Timeout check: restart pulse at E0 -> tick high in cycles after E3, E7, E11, ...; T=1 after E8; L=1 after E20; both stay 1 through E100 (elapsed saturated at 5).
REQ-031 Restart-mid-count check: restart at E0, then restart again at E10 (T=1) -> T=0 after E10, T=1 after E18, L=1 after E30; restart coincident with a tick cycle -> elapsed = 0, not 1.
REQ-032 Debounce check: SN 0->1 held -> S=1 exactly 5 edges after first sampling (2 sync + 3 stable); 2-cycle SN pulse -> S never rises.
REQ-033 Sticky flag check: S=1 for 1 cycle, then 0 -> W stays 1; restart -> W=0 next edge; S=1 together with restart -> W=0 that edge and W=1 the following edge if S is still 1.
